// File: rtl/ssd_scan_mux.sv
// Four-digit common-anode seven-segment scanner: shadowed hex value, one digit per
// refresh slot, leading-zero blanking and a one-cycle dead time between digits.

module ssd_digit_lane #(
    parameter int IDX = 0
) (
    input  logic [3:0] nib,
    input  logic       upper_zero,
    input  logic       blank_lz,
    input  logic [1:0] idx,
    input  logic       enable,
    input  logic       slot_live,
    input  logic       dp_req,
    output logic       lit,
    output logic       dp_lit
);
    logic blank;
    logic sel;

    // The rightmost digit is never blanked, so a zero value still shows "0".
    assign blank  = blank_lz && (IDX != 0) && upper_zero && (nib == 4'h0);
    assign sel    = (idx == 2'(IDX));
    assign lit    = enable && slot_live && sel && !blank;
    assign dp_lit = lit && dp_req;
endmodule

module ssd_scan_mux #(
    parameter int DIV_COUNT = 100000,
    parameter int DIV_W     = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        load,
    input  logic        enable,
    input  logic        blank_lz,
    output logic [3:0]  nibble,
    output logic [3:0]  an,
    output logic        dp,
    output logic [1:0]  digit_idx
);
    localparam int NUM_DIG = 4;
    localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(DIV_COUNT - 1);

    typedef struct packed {
        logic [15:0] val;
        logic [3:0]  dp;
    } shadow_t;

    logic [DIV_W-1:0]   cnt;
    logic [1:0]         idx;
    shadow_t            shadow;
    logic               slot_end;
    logic               slot_live;
    logic [NUM_DIG:1]   zero_from;
    logic [NUM_DIG-1:0] lit;
    logic [NUM_DIG-1:0] dp_lit;

    assign slot_end  = (cnt == CNT_LAST);
    assign slot_live = (cnt != '0);

    // zero_from[i]: every digit at index i and above is zero.
    assign zero_from[NUM_DIG] = 1'b1;
    genvar g;
    generate
        for (g = NUM_DIG - 1; g >= 1; g--) begin : g_zero
            assign zero_from[g] = zero_from[g+1] && (shadow.val[4*g +: 4] == 4'h0);
        end

        for (g = 0; g < NUM_DIG; g++) begin : g_lane
            ssd_digit_lane #(.IDX(g)) u_lane (
                .nib        (shadow.val[4*g +: 4]),
                .upper_zero (zero_from[g+1]),
                .blank_lz   (blank_lz),
                .idx        (idx),
                .enable     (enable),
                .slot_live  (slot_live),
                .dp_req     (shadow.dp[g]),
                .lit        (lit[g]),
                .dp_lit     (dp_lit[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (load) begin
            shadow <= '{val: value, dp: dp_in};
        end
    end

    // Outputs reflect the pre-edge scan state and shadow; one cycle of latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_idx <= 2'd0;
            nibble    <= 4'h0;
            an        <= 4'hF;
            dp        <= 1'b1;
        end else begin
            digit_idx <= idx;
            nibble    <= shadow.val[4*idx +: 4];
            an        <= ~lit;
            dp        <= ~|dp_lit;
        end
    end
endmodule

// File: tb/tb_ssd_scan_mux.sv
// Directed plus randomized bench for ssd_scan_mux against a cycle-index reference
// model (slot and digit derived arithmetically from edges since reset).

module tb_ssd_scan_mux;
    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] value = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic        load = 1'b0;
    logic        enable = 1'b0;
    logic        blank_lz = 1'b0;
    logic [3:0]  nibble;
    logic [3:0]  an;
    logic        dp;
    logic [1:0]  digit_idx;

    int checks = 0;
    int errors = 0;

    int          k = 0;
    logic [15:0] m_val = 16'h0;
    logic [3:0]  m_dp = 4'h0;

    always #5 clk = ~clk;

    ssd_scan_mux #(.DIV_COUNT(DIV), .DIV_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .value     (value),
        .dp_in     (dp_in),
        .load      (load),
        .enable    (enable),
        .blank_lz  (blank_lz),
        .nibble    (nibble),
        .an        (an),
        .dp        (dp),
        .digit_idx (digit_idx)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge; expected outputs come from the model state before the edge.
    task automatic tick();
        int          cnt_m;
        int          idx_m;
        bit          blank;
        bit          act;
        logic [3:0]  e_an;
        logic        e_dp;
        logic [3:0]  e_nib;
        logic        ld;
        logic [15:0] nv;
        logic [3:0]  nd;
        cnt_m = k % DIV;
        idx_m = (k / DIV) % 4;
        e_nib = 4'((m_val >> (4 * idx_m)) & 16'hF);
        blank = blank_lz && (idx_m != 0) && ((m_val >> (4 * idx_m)) == 16'h0);
        act   = enable && (cnt_m != 0) && !blank;
        e_an  = act ? ~(4'b0001 << idx_m) : 4'hF;
        e_dp  = act ? ~m_dp[idx_m] : 1'b1;
        ld = load;
        nv = value;
        nd = dp_in;
        @(posedge clk);
        #1;
        k++;
        if (ld) begin
            m_val = nv;
            m_dp  = nd;
        end
        chk("an", {12'h0, an}, {12'h0, e_an});
        chk("nibble", {12'h0, nibble}, {12'h0, e_nib});
        chk("dp", {15'h0, dp}, {15'h0, e_dp});
        chk("digit_idx", {14'h0, digit_idx}, 16'(idx_m));
    endtask

    initial begin
        int low_cnt [4];
        int dead;
        int bad;
        int dp_low;
        logic [3:0] seen_low;
        bit found;

        // 1: asynchronous reset before any clock edge
        #1 rst_n = 1'b0;
        #2;
        chk("rst_an", {12'h0, an}, 16'h000F);
        chk("rst_nibble", {12'h0, nibble}, 16'h0000);
        chk("rst_dp", {15'h0, dp}, 16'h0001);
        chk("rst_idx", {14'h0, digit_idx}, 16'h0000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        k = 0; m_val = 16'h0; m_dp = 4'h0;

        // 2: plain scan of 1A3F
        value = 16'h1A3F; load = 1'b1; enable = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 4; i++) low_cnt[i] = 0;
        dead = 0; bad = 0;
        for (int c = 0; c < 16; c++) begin
            tick();
            case (an)
                4'b1110: begin low_cnt[0]++; if (nibble !== 4'hF) bad++; end
                4'b1101: begin low_cnt[1]++; if (nibble !== 4'h3) bad++; end
                4'b1011: begin low_cnt[2]++; if (nibble !== 4'hA) bad++; end
                4'b0111: begin low_cnt[3]++; if (nibble !== 4'h1) bad++; end
                4'b1111: dead++;
                default: bad++;
            endcase
        end
        for (int i = 0; i < 4; i++) chk("lit_cycles", 16'(low_cnt[i]), 16'd3);
        chk("dead_cycles", 16'(dead), 16'd4);
        chk("nibble_by_anode", 16'(bad), 16'd0);

        // 3: leading-zero blanking
        blank_lz = 1'b1; value = 16'h0042; load = 1'b1;
        tick();
        load = 1'b0;
        seen_low = 4'h0;
        for (int c = 0; c < 16; c++) begin tick(); seen_low |= ~an; end
        chk("lz_0042_anodes", {12'h0, seen_low}, 16'h0003);
        value = 16'h0000; load = 1'b1;
        tick();
        load = 1'b0;
        seen_low = 4'h0; bad = 0;
        for (int c = 0; c < 16; c++) begin
            tick();
            seen_low |= ~an;
            if (nibble !== 4'h0) bad++;
        end
        chk("lz_0000_anodes", {12'h0, seen_low}, 16'h0001);
        chk("lz_0000_nibble", 16'(bad), 16'd0);

        // 4: decimal point on digit 2 only
        blank_lz = 1'b0; value = 16'h1A3F; dp_in = 4'b0100; load = 1'b1;
        tick();
        load = 1'b0;
        dp_low = 0; bad = 0;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (dp === 1'b0) begin
                dp_low++;
                if (an !== 4'b1011) bad++;
            end
        end
        chk("dp_low_cycles", 16'(dp_low), 16'd3);
        chk("dp_wrong_digit", 16'(bad), 16'd0);

        // 5: value changes without load are ignored; enable gating
        for (int c = 0; c < 8; c++) begin
            value = 16'($urandom);
            dp_in = 4'($urandom);
            tick();
        end
        while ((k % DIV) != 2) tick();
        enable = 1'b0;
        tick();
        chk("en_off_an", {12'h0, an}, 16'h000F);
        chk("en_off_dp", {15'h0, dp}, 16'h0001);
        for (int c = 0; c < 5; c++) tick();
        enable = 1'b1;
        for (int c = 0; c < 8; c++) tick();

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            value    = 16'($urandom);
            if ($urandom_range(0, 3) == 0) value = value & 16'h00FF;
            if ($urandom_range(0, 7) == 0) value = 16'h0;
            dp_in    = 4'($urandom);
            load     = ($urandom_range(0, 5) == 0);
            enable   = ($urandom_range(0, 7) != 0);
            blank_lz = 1'($urandom);
            tick();
        end
        load = 1'b0; enable = 1'b1; blank_lz = 1'b0;
        value = 16'h1A3F; load = 1'b1;
        tick();
        load = 1'b0;

        // 6: asynchronous reset while digit 2 is lit
        found = 1'b0;
        for (int c = 0; c < 32 && !found; c++) begin
            tick();
            if (an === 4'b1011) found = 1'b1;
        end
        chk("digit2_reached", {15'h0, found}, 16'h0001);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_an", {12'h0, an}, 16'h000F);
        chk("midrst_nibble", {12'h0, nibble}, 16'h0000);
        chk("midrst_dp", {15'h0, dp}, 16'h0001);
        chk("midrst_idx", {14'h0, digit_idx}, 16'h0000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        k = 0; m_val = 16'h0; m_dp = 4'h0;
        value = 16'h4321; load = 1'b1;
        tick();
        load = 1'b0;
        chk("post_rst_dead", {12'h0, an}, 16'h000F);
        tick();
        chk("post_rst_first", {12'h0, an}, 16'h000E);
        chk("post_rst_nibble", {12'h0, nibble}, 16'h0001);
        for (int c = 0; c < 16; c++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
